lmg_sequencer: RTL

- Sequences the legal-move generator (LMG) behind the Avalon-MM control slave.
- On a start command: latches the 256-bit board, resets the LMG, and runs it.
- While the LMG runs, drains its 152-bit move FIFO and writes each move as five 32-bit words into the result RAM at word address RESULT_BASE and up.
- Reports busy, done, move count and overflow to the control register file.

---
 rtl/lmg_pkg.sv | 38 +++
 rtl/lmg_move_packer.sv | 28 ++
 rtl/lmg_sequencer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/lmg_pkg.sv
// Shared types and constants for the legal-move-generator sequencer.
// Defines the FSM state encoding and how a 152-bit move splits into result-RAM words.
package lmg_pkg;

    localparam int unsigned MOVE_W          = 152;
    localparam int unsigned BOARD_W         = 256;
    localparam int unsigned WORD_W          = 32;
    localparam int unsigned WORDS_PER_MOVE  = 5;
    localparam int unsigned RESULT_BASE_DEF = 16;
    localparam int unsigned KIDX_W          = 3;
    localparam int unsigned COUNT_W         = 8;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RST  = 3'd1,
        S_RUN  = 3'd2,
        S_POP  = 3'd3,
        S_WR   = 3'd4,
        S_DONE = 3'd5
    } lmg_state_e;

    // Word k of a move; the last word carries the top 24 bits zero-extended.
    function automatic logic [WORD_W-1:0] move_word(input logic [MOVE_W-1:0] m,
                                                    input logic [KIDX_W-1:0] k);
        logic [WORD_W-1:0] w;
        w = '0;
        case (k)
            3'd0:    w = m[0*WORD_W +: WORD_W];
            3'd1:    w = m[1*WORD_W +: WORD_W];
            3'd2:    w = m[2*WORD_W +: WORD_W];
            3'd3:    w = m[3*WORD_W +: WORD_W];
            3'd4:    w = {8'h00, m[MOVE_W-1:4*WORD_W]};
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/lmg_move_packer.sv
// Holds the popped move and selects one 32-bit result word from it.
// On the load cycle the incoming FIFO head is bypassed so word 0 is available immediately.
module lmg_move_packer
    import lmg_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                i_load,
    input  logic [MOVE_W-1:0]   i_move,
    input  logic [KIDX_W-1:0]   i_sel,
    output logic [WORD_W-1:0]   o_word_c
);

    logic [MOVE_W-1:0] r_hold;
    logic [MOVE_W-1:0] w_src;

    always_ff @(posedge clk) begin : p_hold
        if (reset) begin
            r_hold <= '0;
        end else if (i_load) begin
            r_hold <= i_move;
        end
    end

    assign w_src    = i_load ? i_move : r_hold;
    assign o_word_c = move_word(w_src, i_sel);

endmodule

// File: rtl/lmg_sequencer.sv
// Runs the legal-move generator for one board and drains its move FIFO into result RAM.
// All outputs are registered from the next-state decode, so they track the state with no lag.
module lmg_sequencer
    import lmg_pkg::*;
#(
    parameter int unsigned RESULT_BASE = RESULT_BASE_DEF,
    parameter int unsigned ADDR_WIDTH  = 15,
    parameter int unsigned MAX_MOVES   = 64,
    parameter int unsigned RST_CYCLES  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [BOARD_W-1:0]     board_in,
    output logic [BOARD_W-1:0]     lmg_board,
    output logic                   lmg_reset,
    input  logic                   lmg_done,
    input  logic                   fifo_empty,
    output logic                   fifo_rdreq,
    input  logic [MOVE_W-1:0]      fifo_q,
    output logic                   ram_we,
    output logic [ADDR_WIDTH-1:0]  ram_addr,
    output logic [WORD_W-1:0]      ram_wdata,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_W-1:0]     move_count,
    output logic                   overflow
);

    localparam logic [COUNT_W-1:0] RST_LAST  = COUNT_W'(RST_CYCLES - 1);
    localparam logic [COUNT_W-1:0] WORD_LAST = COUNT_W'(WORDS_PER_MOVE - 1);
    localparam logic [COUNT_W-1:0] MAX_CNT   = COUNT_W'(MAX_MOVES);
    localparam logic [COUNT_W-1:0] SAT_CNT   = '1;

    lmg_state_e              r_state;
    lmg_state_e              w_state_nxt;
    logic [COUNT_W-1:0]      r_cnt;
    logic                    w_start_ok;
    logic                    w_load;
    logic [KIDX_W-1:0]       w_k_nxt;
    logic [WORD_W-1:0]       w_word;
    logic [ADDR_WIDTH-1:0]   w_move_addr;
    logic                    w_lmg_reset_nxt;
    logic                    w_busy_nxt;
    logic                    w_done_nxt;
    logic                    w_rdreq_nxt;
    logic                    w_we_nxt;

    // A start is honoured only when idle or finished, and abort always takes priority.
    assign w_start_ok  = start && !abort && (r_state == S_IDLE || r_state == S_DONE);
    assign w_load      = (r_state == S_POP);
    assign w_k_nxt     = (r_state == S_WR) ? (KIDX_W'(r_cnt) + KIDX_W'(1)) : '0;
    assign w_move_addr = ADDR_WIDTH'(RESULT_BASE)
                       + ADDR_WIDTH'(WORDS_PER_MOVE * 32'(move_count));

    lmg_move_packer u_packer (
        .clk      (clk),
        .reset    (reset),
        .i_load   (w_load),
        .i_move   (fifo_q),
        .i_sel    (w_k_nxt),
        .o_word_c (w_word)
    );

    always_ff @(posedge clk) begin : p_state
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin : p_next_state
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: if (start) w_state_nxt = S_RST;
                S_RST:          if (r_cnt == RST_LAST) w_state_nxt = S_RUN;
                // FIFO before lmg_done so a final entry is never lost.
                S_RUN: begin
                    if (!fifo_empty)   w_state_nxt = S_POP;
                    else if (lmg_done) w_state_nxt = S_DONE;
                end
                S_POP:          w_state_nxt = (move_count >= MAX_CNT) ? S_RUN : S_WR;
                S_WR:           if (r_cnt == WORD_LAST) w_state_nxt = S_RUN;
                default:        w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin : p_outputs
        w_lmg_reset_nxt = 1'b0;
        w_busy_nxt      = 1'b0;
        w_done_nxt      = 1'b0;
        w_rdreq_nxt     = 1'b0;
        w_we_nxt        = 1'b0;
        case (w_state_nxt)
            S_IDLE: w_lmg_reset_nxt = 1'b1;
            S_RST: begin
                w_lmg_reset_nxt = 1'b1;
                w_busy_nxt      = 1'b1;
            end
            S_RUN:  w_busy_nxt = 1'b1;
            S_POP: begin
                w_busy_nxt  = 1'b1;
                w_rdreq_nxt = 1'b1;
            end
            S_WR: begin
                w_busy_nxt = 1'b1;
                w_we_nxt   = 1'b1;
            end
            S_DONE: begin
                w_done_nxt      = 1'b1;
                w_lmg_reset_nxt = 1'b1;
            end
            default: w_lmg_reset_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin : p_datapath
        if (reset) begin
            lmg_board  <= '0;
            lmg_reset  <= 1'b1;
            fifo_rdreq <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            move_count <= '0;
            overflow   <= 1'b0;
            r_cnt      <= '0;
        end else begin
            lmg_reset  <= w_lmg_reset_nxt;
            busy       <= w_busy_nxt;
            done       <= w_done_nxt;
            fifo_rdreq <= w_rdreq_nxt;
            ram_we     <= w_we_nxt;
            ram_wdata  <= w_we_nxt ? w_word : '0;
            if (!w_we_nxt) begin
                ram_addr <= '0;
            end else if (r_state == S_POP) begin
                ram_addr <= w_move_addr;
            end else begin
                ram_addr <= ram_addr + ADDR_WIDTH'(1);
            end

            // Shared cycle counter: RST hold length, then word index within WR.
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (r_state == S_RST || r_state == S_WR) begin
                r_cnt <= r_cnt + COUNT_W'(1);
            end

            if (w_start_ok) begin
                lmg_board  <= board_in;
                move_count <= '0;
                overflow   <= 1'b0;
            end else if (r_state == S_POP) begin
                if (move_count != SAT_CNT) move_count <= move_count + COUNT_W'(1);
                if (move_count >= MAX_CNT) overflow   <= 1'b1;
            end
        end
    end

endmodule
